// File: rtl/arm_mem_pkg.sv
// Shared types and default sizes for the instruction/data memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : winner of an IDLE arbitration round
package arm_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 32;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_D  = 2'd2
    } arb_state_t;

    typedef enum logic [0:0] {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_starve_ctr.sv
// Saturating counter of data grants issued while a fetch was waiting.
//   clk, reset : clock, synchronous active-low reset
//   inc        : count one more data grant (holds at LIMIT)
//   clr        : return to zero, wins over inc
//   sat        : count has reached LIMIT
module mem_starve_ctr
    import arm_mem_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned   CW      = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: clear first, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// Data wins ties unless the fetch port has been passed over STARVE_LIMIT times.
//   clk, reset            : clock, synchronous active-low reset
//   if_req/if_addr        : fetch request (held until if_ack)
//   if_rdata/if_ack       : fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata : data request (held until d_ack)
//   d_rdata/d_ack         : load data, one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory command
//   mem_rdata/mem_ready   : memory response
//   busy                  : a transaction is in flight
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy
);

    arb_state_t            state_q,     state_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_hold_q,   if_hold_d;
    logic [DATA_WIDTH-1:0] d_hold_q,    d_hold_d;

    arb_owner_t winner;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;

    mem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );

    // IDLE arbitration: data first, unless fetch has been starved long enough
    always_comb begin
        winner = OWNER_D;
        if (!d_req || (if_req && starve_sat)) begin
            winner = OWNER_IF;
        end
    end

    // next state, latched memory command and starvation bookkeeping
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    mem_req_d = 1'b1;
                    if (winner == OWNER_D) begin
                        state_d     = OWN_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // only a grant that bypasses a waiting fetch counts
                        starve_inc  = if_req;
                        starve_clr  = !if_req;
                    end else begin
                        state_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_clr  = 1'b1;
                    end
                end
            end
            OWN_IF, OWN_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // completion pulses come straight from the memory handshake
    assign if_ack = mem_ready && (state_q == OWN_IF);
    assign d_ack  = mem_ready && (state_q == OWN_D);

    // read-data hold registers; a store ack leaves the data hold untouched
    always_comb begin
        if_hold_d = if_hold_q;
        d_hold_d  = d_hold_q;
        if (if_ack) begin
            if_hold_d = mem_rdata;
        end
        if (d_ack && !mem_we_q) begin
            d_hold_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_hold_q   <= '0;
            d_hold_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_hold_q   <= if_hold_d;
            d_hold_q    <= d_hold_d;
        end
    end

    assign if_rdata  = if_ack ? mem_rdata : if_hold_q;
    assign d_rdata   = d_ack  ? mem_rdata : d_hold_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It sits between the core's fetch/memory stages and the memory model. It serialises requests through a small FSM, gives data accesses priority, and uses a starvation counter to guarantee fetch progress. Acks are the completion handshake the hazard unit uses to stall fetch or memory stages.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending (≥1)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- if_req  in  1  fetch request, held high until if_ack
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_rdata  out  DATA_WIDTH  fetched instruction
- if_ack  out  1  fetch complete, one cycle
- d_req  in  1  data request, held high until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data
- d_ack  out  1  data access complete, one cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current request this cycle
- busy  out  1  FSM not in IDLE

## Operation
- FSM states:
  - IDLE: no transaction.
  - OWN_IF: fetch owns the memory.
  - OWN_D: data port owns the memory.
- IDLE grant decision:
  - d_req and not (if_req and starve_cnt == STARVE_LIMIT) → OWN_D.
  - Else if_req → OWN_IF.
  - Else stay in IDLE.
- On grant, mem_req, mem_we, mem_addr and mem_wdata are registered from the winner's port. A fetch grant forces mem_we = 0 and mem_wdata = 0.
- OWN_x: mem_* outputs are held constant until mem_ready. On mem_ready, go to IDLE and clear mem_req and mem_we.
- Ack and read data:
  - x_ack = mem_ready & (state == OWN_x), combinational.
  - x_rdata = mem_rdata while x_ack is high. Otherwise it shows the hold register, which captures mem_rdata on every x_ack.
  - Stores leave d_rdata's hold register unchanged.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each OWN_D grant made while if_req = 1.
  - Clears on each OWN_IF grant, and on an OWN_D grant made while if_req = 0.
- Protocol violations:
  - A requester that drops req before its ack is illegal. The arbiter still completes the transaction and pulses ack.
  - Changing addr, we or wdata mid-transaction has no effect, because the values are latched at grant.

## Timing
- Reset (reset = 0 at an edge) sets:
  - state = IDLE, starve_cnt = 0;
  - mem_req = mem_we = 0, mem_addr = mem_wdata = 0;
  - both hold registers = 0, so if_rdata = d_rdata = 0;
  - if_ack = d_ack = busy = 0.
- Reset mid-transaction abandons it: no ack, mem_req low in the cycle after the reset edge.
- Latency: request seen in IDLE at cycle N → mem_req high in N+1. If mem_ready arrives in cycle M ≥ N+1, ack is in M and the FSM is in IDLE at M+1. The next grant is decided at M+1, with mem_req at M+2.
- With zero-wait memory (mem_ready = 1 whenever mem_req = 1), one access completes every 2 cycles.
- Simultaneous if_req and d_req: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- A requester sees ack in cycle M and drops or changes req at M+1. The arbiter samples req at M+1, so no duplicate issue occurs.
- mem_ready while state == IDLE is ignored: no ack, no state change.

## Structure
- Package arm_mem_pkg:
  - typedef arb_state_t {IDLE, OWN_IF, OWN_D};
  - typedef arb_owner_t;
  - default width constants.
- One sub-module, mem_starve_ctr: a saturating counter of width $clog2(STARVE_LIMIT+1) with inc, clr and sat outputs.
- Everything else (FSM, request registers, hold registers, ack decode) lives in mem_port_arbiter.

## Test plan
- Reset: drive reset = 0 for 2 cycles with both reqs high → all outputs 0 and busy = 0. Release → d is granted, mem_req = 1 one cycle later.
- Single fetch: if_req = 1, if_addr = 0x100, memory returns 0xE3A00001 after 3 wait cycles → mem_addr = 0x100, mem_we = 0, if_ack pulses once with if_rdata = 0xE3A00001. if_rdata holds 0xE3A00001 afterwards.
- Store then load: d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, then a load from 0x200 → mem_we = 1 then 0, d_ack pulses twice, d_rdata = 0xDEADBEEF after the load.
- Starvation, STARVE_LIMIT = 4, zero-wait memory, both reqs permanently high → grant sequence D,D,D,D,IF repeating, with exactly one IDLE cycle between transactions.
- Reset mid-transaction: assert reset = 0 while in OWN_D waiting on mem_ready → no d_ack, mem_req = 0 and state = IDLE on the next cycle, starve_cnt = 0.
- Stray mem_ready: pulse mem_ready in IDLE → no ack and no change to the hold registers.
